// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh router constants, destination codes and allocator state type
package noc_pkg;

    localparam int NUM_PORTS = 5;
    localparam int PTR_W     = 3;

    localparam int P_LOCAL = 0;
    localparam int P_NORTH = 1;
    localparam int P_SOUTH = 2;
    localparam int P_EAST  = 3;
    localparam int P_WEST  = 4;

    localparam logic [2:0] DEST_LOCAL = 3'd1;
    localparam logic [2:0] DEST_NORTH = 3'd2;
    localparam logic [2:0] DEST_SOUTH = 3'd3;
    localparam logic [2:0] DEST_EAST  = 3'd4;
    localparam logic [2:0] DEST_WEST  = 3'd5;

    typedef enum logic {
        ALLOC_IDLE   = 1'b0,
        ALLOC_LOCKED = 1'b1
    } alloc_state_e;

    // destination_port code (1..5) to one-hot request bit; other codes request nothing
    function automatic logic [NUM_PORTS-1:0] dest_to_req(input logic [2:0] code);
        logic [NUM_PORTS-1:0] r;
        r = '0;
        if (code >= DEST_LOCAL && code <= DEST_WEST) begin
            r[code - 3'd1] = 1'b1;
        end
        return r;
    endfunction

    function automatic logic is_onehot(input logic [NUM_PORTS-1:0] v);
        return (v != '0) && ((v & (v - 1'b1)) == '0);
    endfunction

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(NUM_PORTS - 1)) ? '0 : p + 1'b1;
    endfunction

endpackage

// File: rtl/switch_allocator_if.sv
// rtl/switch_allocator_if.sv - request/grant bundle between input ports and the allocator
interface switch_allocator_if;
    import noc_pkg::*;

    logic [NUM_PORTS*NUM_PORTS-1:0] req_in;
    logic [NUM_PORTS-1:0]           valid_in;
    logic [NUM_PORTS-1:0]           tail_in;
    logic [NUM_PORTS-1:0]           out_ready;
    logic [NUM_PORTS*NUM_PORTS-1:0] grant;
    logic [NUM_PORTS-1:0]           in_ack;

    modport master (
        output req_in, valid_in, tail_in, out_ready,
        input  grant, in_ack
    );

    modport slave (
        input  req_in, valid_in, tail_in, out_ready,
        output grant, in_ack
    );

endinterface

// File: rtl/rr_arbiter5.sv
// rtl/rr_arbiter5.sv - combinational 5-way round-robin pick starting at ptr, wrapping 4->0
module rr_arbiter5
    import noc_pkg::*;
(
    input  logic [NUM_PORTS-1:0] req,
    input  logic [PTR_W-1:0]     ptr,
    output logic [NUM_PORTS-1:0] gnt_onehot,
    output logic [PTR_W-1:0]     gnt_idx
);

    logic [PTR_W:0]   sum;
    logic [PTR_W-1:0] idx;
    logic             found;

    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        found      = 1'b0;
        sum        = '0;
        idx        = '0;
        for (int k = 0; k < NUM_PORTS; k++) begin
            sum = {1'b0, ptr} + (PTR_W+1)'(k);
            if (sum >= (PTR_W+1)'(NUM_PORTS)) begin
                sum = sum - (PTR_W+1)'(NUM_PORTS);
            end
            idx = sum[PTR_W-1:0];
            if (!found && req[idx]) begin
                found           = 1'b1;
                gnt_idx         = idx;
                gnt_onehot[idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/switch_allocator.sv
// rtl/switch_allocator.sv - per-output wormhole allocator with round-robin fairness
module switch_allocator
    import noc_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    switch_allocator_if.slave  bus
);

    alloc_state_e                         state_q [NUM_PORTS];
    alloc_state_e                         state_d [NUM_PORTS];
    logic [PTR_W-1:0]                     owner_q [NUM_PORTS];
    logic [PTR_W-1:0]                     owner_d [NUM_PORTS];
    logic [PTR_W-1:0]                     ptr_q   [NUM_PORTS];
    logic [PTR_W-1:0]                     ptr_d   [NUM_PORTS];

    logic [NUM_PORTS-1:0]                 cand_ok;
    logic [NUM_PORTS-1:0]                 locked_in;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  arb_req;
    logic [NUM_PORTS-1:0][NUM_PORTS-1:0]  arb_onehot;
    logic [NUM_PORTS-1:0][PTR_W-1:0]      arb_idx;
    logic [NUM_PORTS-1:0]                 owner_valid;
    logic [NUM_PORTS-1:0]                 owner_tail;
    logic [NUM_PORTS-1:0]                 xfer;

    // An input already holding a lock is hidden from every other output's arbiter
    always_comb begin
        cand_ok   = '0;
        locked_in = '0;
        arb_req   = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            cand_ok[i] = bus.valid_in[i] & is_onehot(bus.req_in[NUM_PORTS*i +: NUM_PORTS]);
            for (int o = 0; o < NUM_PORTS; o++) begin
                if (state_q[o] == ALLOC_LOCKED && owner_q[o] == PTR_W'(i)) begin
                    locked_in[i] = 1'b1;
                end
            end
        end
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                arb_req[o][i] = cand_ok[i] & bus.req_in[NUM_PORTS*i + o] & ~locked_in[i];
            end
        end
    end

    for (genvar o = 0; o < NUM_PORTS; o++) begin : g_arb
        rr_arbiter5 u_arb (
            .req        (arb_req[o]),
            .ptr        (ptr_q[o]),
            .gnt_onehot (arb_onehot[o]),
            .gnt_idx    (arb_idx[o])
        );
    end

    always_comb begin
        owner_valid = '0;
        owner_tail  = '0;
        xfer        = '0;
        bus.grant   = '0;
        bus.in_ack  = '0;
        for (int o = 0; o < NUM_PORTS; o++) begin
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (owner_q[o] == PTR_W'(i)) begin
                    owner_valid[o] = bus.valid_in[i];
                    owner_tail[o]  = bus.tail_in[i];
                    if (state_q[o] == ALLOC_LOCKED) begin
                        bus.grant[NUM_PORTS*o + i] = 1'b1;
                    end
                end
            end
            xfer[o] = (state_q[o] == ALLOC_LOCKED) & owner_valid[o] & bus.out_ready[o] & ~rst;
            for (int i = 0; i < NUM_PORTS; i++) begin
                if (xfer[o] && owner_q[o] == PTR_W'(i)) begin
                    bus.in_ack[i] = 1'b1;
                end
            end
        end
    end

    // Pointer moves only on release, so a stalled wormhole never loses its turn
    always_comb begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            state_d[o] = state_q[o];
            owner_d[o] = owner_q[o];
            ptr_d[o]   = ptr_q[o];
            case (state_q[o])
                ALLOC_IDLE: begin
                    if (|arb_onehot[o]) begin
                        owner_d[o] = arb_idx[o];
                        state_d[o] = ALLOC_LOCKED;
                    end
                end
                ALLOC_LOCKED: begin
                    if (xfer[o] && owner_tail[o]) begin
                        state_d[o] = ALLOC_IDLE;
                        ptr_d[o]   = ptr_next(owner_q[o]);
                    end
                end
                default: state_d[o] = ALLOC_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        for (int o = 0; o < NUM_PORTS; o++) begin
            if (rst) begin
                state_q[o] <= ALLOC_IDLE;
                owner_q[o] <= '0;
                ptr_q[o]   <= '0;
            end else begin
                state_q[o] <= state_d[o];
                owner_q[o] <= owner_d[o];
                ptr_q[o]   <= ptr_d[o];
            end
        end
    end

endmodule

// File: tb/tb_switch_allocator.sv
// tb/tb_switch_allocator.sv - scoreboard bench for switch_allocator with directed vectors
module tb_switch_allocator;

    logic clk;
    logic rst;

    switch_allocator_if bus ();

    switch_allocator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [24:0] g;
        logic [4:0]  a;
        logic [15:0] id;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp  = 0;
    int   n_fail = 0;
    int   step_no = 0;

    localparam logic [4:0] RL = 5'b00001;
    localparam logic [4:0] RN = 5'b00010;
    localparam logic [4:0] RS = 5'b00100;
    localparam logic [4:0] RE = 5'b01000;
    localparam logic [4:0] RW = 5'b10000;
    localparam logic [4:0] RX = 5'b00000;

    function automatic logic [24:0] mk(input logic [4:0] d0, d1, d2, d3, d4);
        return {d4, d3, d2, d1, d0};
    endfunction

    function automatic logic [24:0] gb(input int o, input int i);
        logic [24:0] r;
        r = '0;
        r[5*o + i] = 1'b1;
        return r;
    endfunction

    task automatic step(input logic r, input logic [24:0] req, input logic [4:0] v, t, rdy,
                        input logic [24:0] eg, input logic [4:0] ea);
        exp_t e;
        #1;
        rst           = r;
        bus.req_in    = req;
        bus.valid_in  = v;
        bus.tail_in   = t;
        bus.out_ready = rdy;
        step_no++;
        e.g  = eg;
        e.a  = ea;
        e.id = 16'(step_no);
        exp_q.push_back(e);
        @(posedge clk);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            n_cmp++;
            if (bus.grant !== e.g) begin
                n_fail++;
                $display("FAIL grant step %0d: got %b want %b", e.id, bus.grant, e.g);
            end
            n_cmp++;
            if (bus.in_ack !== e.a) begin
                n_fail++;
                $display("FAIL in_ack step %0d: got %b want %b", e.id, bus.in_ack, e.a);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [24:0] all_e;
        logic [24:0] w3;
        logic [24:0] n30;
        logic [24:0] par;
        logic [24:0] ill;
        logic [24:0] e03;
        all_e = mk(RE, RE, RE, RE, RE);
        w3    = mk(RX, RW, RW, RX, RW);
        n30   = mk(RN, RX, RX, RN, RX);
        par   = mk(RW, RE, RS, RN, RL);
        ill   = mk(RX, RS, 5'b01010, RX, RX);
        e03   = mk(RE, RX, RX, RE, RX);

        rst = 1'b1;
        bus.req_in = all_e; bus.valid_in = '1; bus.tail_in = '0; bus.out_ready = '1;
        @(posedge clk);

        // reset held two cycles, then input 0 wins east
        step(1, all_e, 5'b11111, 5'b00000, 5'b11111, '0, 5'b00000);
        step(0, all_e, 5'b11111, 5'b00000, 5'b11111, '0, 5'b00000);
        step(0, all_e, 5'b11111, 5'b00000, 5'b11111, gb(3, 0), 5'b00001);
        step(0, all_e, 5'b00001, 5'b00001, 5'b11111, gb(3, 0), 5'b00001);
        step(0, '0,    5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        // west contention: owners 1, 2, 4, 1
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, '0, 5'b00000);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, gb(4, 1), 5'b00010);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, '0, 5'b00000);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, gb(4, 2), 5'b00100);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, '0, 5'b00000);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, gb(4, 4), 5'b10000);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, '0, 5'b00000);
        step(0, w3, 5'b10110, 5'b10110, 5'b11111, gb(4, 1), 5'b00010);
        step(0, '0, 5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        // wormhole: input 3 holds north through stalls, input 0 waits
        step(0, mk(RX, RX, RX, RN, RX), 5'b01000, 5'b00000, 5'b11111, '0, 5'b00000);
        step(0, n30, 5'b01001, 5'b00001, 5'b11111, gb(1, 3), 5'b01000);
        step(0, n30, 5'b01001, 5'b00001, 5'b11101, gb(1, 3), 5'b00000);
        step(0, n30, 5'b01001, 5'b00001, 5'b11111, gb(1, 3), 5'b01000);
        step(0, n30, 5'b01001, 5'b00001, 5'b11111, gb(1, 3), 5'b01000);
        step(0, n30, 5'b01001, 5'b01001, 5'b11101, gb(1, 3), 5'b00000);
        step(0, n30, 5'b01001, 5'b01001, 5'b11111, gb(1, 3), 5'b01000);
        step(0, n30, 5'b00001, 5'b00001, 5'b11111, '0, 5'b00000);
        step(0, n30, 5'b00001, 5'b00001, 5'b11111, gb(1, 0), 5'b00001);
        step(0, '0,  5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        // five parallel transfers
        step(0, par, 5'b11111, 5'b00000, 5'b11111, '0, 5'b00000);
        step(0, par, 5'b11111, 5'b00000, 5'b11111,
             gb(4, 0) | gb(3, 1) | gb(2, 2) | gb(1, 3) | gb(0, 4), 5'b11111);
        step(0, par, 5'b11111, 5'b11111, 5'b11111,
             gb(4, 0) | gb(3, 1) | gb(2, 2) | gb(1, 3) | gb(0, 4), 5'b11111);
        step(0, '0,  5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        // multi-hot and zero requests are ignored
        step(0, ill, 5'b00111, 5'b00110, 5'b11111, '0, 5'b00000);
        step(0, ill, 5'b00111, 5'b00110, 5'b11111, gb(2, 1), 5'b00010);
        step(0, ill, 5'b00111, 5'b00110, 5'b11111, '0, 5'b00000);
        step(0, ill, 5'b00111, 5'b00110, 5'b11111, gb(2, 1), 5'b00010);
        step(0, '0,  5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        // reset mid-packet drops the lock and the east pointer
        step(0, mk(RX, RE, RX, RX, RX), 5'b00010, 5'b00000, 5'b11111, '0, 5'b00000);
        step(0, mk(RX, RE, RX, RX, RX), 5'b00010, 5'b00000, 5'b11111, gb(3, 1), 5'b00010);
        step(1, mk(RX, RE, RX, RX, RX), 5'b00010, 5'b00000, 5'b11111, gb(3, 1), 5'b00000);
        step(0, e03, 5'b01001, 5'b01001, 5'b11111, '0, 5'b00000);
        step(0, e03, 5'b01001, 5'b01001, 5'b11111, gb(3, 0), 5'b00001);
        step(0, e03, 5'b01001, 5'b01001, 5'b11111, '0, 5'b00000);
        step(0, e03, 5'b01001, 5'b01001, 5'b11111, gb(3, 3), 5'b01000);
        step(0, '0,  5'b00000, 5'b00000, 5'b11111, '0, 5'b00000);

        repeat (2) @(negedge clk);
        n_cmp++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending want 0", exp_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
